mau_sequencer: RTL and testbench

MAU_SEQUENCER -- requirements
Module: mau_sequencer

---
 rtl/mau_sequencer.sv | 173 +++++++++++++++++
 tb/tb_mau_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mau_sequencer.sv
// Command sequencer for the MAU: latches a command, streams matrix words from RAM,
// drives the operand buses, waits for completion (with timeout) and returns both results.
module mau_sequencer #(
    parameter int MAT_WORDS = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_mode,
    input  logic [7:0]  cmd_base,
    input  logic [15:0] cmd_vec_s,
    input  logic [15:0] cmd_vec_i,
    output logic [7:0]  ram_addr,
    input  logic [15:0] ram_rdata,
    output logic        mau_start,
    output logic        mau_mode,
    output logic [15:0] mau_mat,
    output logic [15:0] mau_dbs,
    output logic [15:0] mau_dbi,
    output logic        mau_drive,
    input  logic        mau_busy,
    output logic        mau_read,
    input  logic [15:0] mau_res_s,
    input  logic [15:0] mau_res_i,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_s,
    output logic [15:0] res_i,
    output logic        timeout_err
);

    localparam int FW = (MAT_WORDS > 1) ? $clog2(MAT_WORDS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        FEED  = 3'd2,
        WAIT  = 3'd3,
        TURN  = 3'd4,
        READ  = 3'd5,
        HOLD  = 3'd6
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic           r_mode;
    logic [7:0]     r_addr;
    logic [15:0]    r_vec_s;
    logic [15:0]    r_vec_i;
    logic [FW-1:0]  r_feed_cnt;
    logic [TW-1:0]  r_wait_cnt;
    logic [15:0]    r_res_s;
    logic [15:0]    r_res_i;
    logic           r_timeout_err;
    logic           w_accept;
    logic           w_abort;

    assign w_accept = cmd_valid && (r_state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_mode        <= 1'b0;
            r_addr        <= 8'h00;
            r_vec_s       <= 16'h0000;
            r_vec_i       <= 16'h0000;
            r_feed_cnt    <= '0;
            r_wait_cnt    <= '0;
            r_res_s       <= 16'h0000;
            r_res_i       <= 16'h0000;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_mode        <= cmd_mode;
                r_addr        <= cmd_base;
                r_vec_s       <= cmd_vec_s;
                r_vec_i       <= cmd_vec_i;
                r_feed_cnt    <= '0;
                r_wait_cnt    <= '0;
                r_timeout_err <= 1'b0;
            end
            // The address runs one word ahead of the data because RAM reads take a cycle.
            if (r_state == START || r_state == FEED) begin
                r_addr <= r_addr + 8'd1;
            end
            if (r_state == FEED) begin
                r_feed_cnt <= r_feed_cnt + 1'b1;
            end
            if (r_state == WAIT && mau_busy) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_abort) begin
                r_timeout_err <= 1'b1;
            end
            if (r_state == READ) begin
                r_res_s <= mau_res_s;
                r_res_i <= mau_res_i;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_abort      = 1'b0;
        mau_start    = 1'b0;
        mau_drive    = 1'b0;
        mau_read     = 1'b0;
        mau_mat      = 16'h0000;
        ram_addr     = 8'h00;
        res_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_state_next = START;
                end
            end
            START: begin
                mau_start    = 1'b1;
                mau_drive    = 1'b1;
                ram_addr     = r_addr;
                w_state_next = FEED;
            end
            FEED: begin
                mau_drive = 1'b1;
                ram_addr  = r_addr;
                mau_mat   = ram_rdata;
                if (r_feed_cnt == FW'(MAT_WORDS - 1)) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                mau_drive = 1'b1;
                if (!mau_busy) begin
                    w_state_next = TURN;
                end else if (r_wait_cnt == TW'(TIMEOUT - 1)) begin
                    w_state_next = IDLE;
                    w_abort      = 1'b1;
                end
            end
            TURN: begin
                mau_read     = 1'b1;
                w_state_next = READ;
            end
            READ: begin
                mau_read     = 1'b1;
                w_state_next = HOLD;
            end
            HOLD: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Operand buses are released together with the drive enable so nothing floats driven.
    assign mau_mode    = mau_drive ? r_mode : 1'b0;
    assign mau_dbs     = mau_drive ? r_vec_s : 16'h0000;
    assign mau_dbi     = mau_drive ? r_vec_i : 16'h0000;
    assign cmd_ready   = (r_state == IDLE) && !reset;
    assign res_s       = r_res_s;
    assign res_i       = r_res_i;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mau_sequencer.sv
// Directed bench for mau_sequencer: a RAM model with one-cycle read latency and
// hand-driven MAU responses, checked cycle by cycle at the falling edge.
module tb_mau_sequencer;

    localparam int MW = 4;
    localparam int TO = 20;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_mode;
    logic [7:0]  cmd_base;
    logic [15:0] cmd_vec_s;
    logic [15:0] cmd_vec_i;
    logic [7:0]  ram_addr;
    logic [15:0] ram_rdata;
    logic        mau_start;
    logic        mau_mode;
    logic [15:0] mau_mat;
    logic [15:0] mau_dbs;
    logic [15:0] mau_dbi;
    logic        mau_drive;
    logic        mau_busy;
    logic        mau_read;
    logic [15:0] mau_res_s;
    logic [15:0] mau_res_i;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_s;
    logic [15:0] res_i;
    logic        timeout_err;

    logic [15:0] ram [256];
    int tests = 0;
    int fails = 0;

    mau_sequencer #(.MAT_WORDS(MW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_base(cmd_base), .cmd_vec_s(cmd_vec_s), .cmd_vec_i(cmd_vec_i),
        .ram_addr(ram_addr), .ram_rdata(ram_rdata),
        .mau_start(mau_start), .mau_mode(mau_mode), .mau_mat(mau_mat),
        .mau_dbs(mau_dbs), .mau_dbi(mau_dbi), .mau_drive(mau_drive),
        .mau_busy(mau_busy), .mau_read(mau_read),
        .mau_res_s(mau_res_s), .mau_res_i(mau_res_i),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_s(res_s), .res_i(res_i), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) ram_rdata <= ram[ram_addr];

    // Called at a falling edge in IDLE; returns at the falling edge of the START cycle.
    task automatic issue(input logic mode, input logic [7:0] base,
                         input logic [15:0] vs, input logic [15:0] vi);
        cmd_mode  = mode;
        cmd_base  = base;
        cmd_vec_s = vs;
        cmd_vec_i = vi;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 60 && !cmd_ready; i++) @(negedge clk);
        tests++;
        if (!cmd_ready) begin fails++; $display("FAIL %s_idle_bound got cmd_ready=%0b exp=1", name, cmd_ready); end
        @(negedge clk);
    endtask

    task automatic test_reset;
        #1;
        tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL rst_cmd_ready got=%0b exp=0", cmd_ready); end
        tests++; if (mau_drive !== 1'b0 || mau_start !== 1'b0 || mau_read !== 1'b0) begin fails++; $display("FAIL rst_mau_ctl got=%0b%0b%0b exp=000", mau_drive, mau_start, mau_read); end
        tests++; if (res_valid !== 1'b0 || timeout_err !== 1'b0) begin fails++; $display("FAIL rst_res got=%0b%0b exp=00", res_valid, timeout_err); end
        tests++; if (ram_addr !== 8'h00 || mau_mat !== 16'h0 || res_s !== 16'h0) begin fails++; $display("FAIL rst_data got=%h %h %h exp=0", ram_addr, mau_mat, res_s); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready got=%0b exp=1", cmd_ready); end
    endtask

    task automatic test_basic;
        logic [15:0] exp_w [4];
        exp_w = '{16'h3AEE, 16'hB800, 16'hBAEE, 16'h3AEE};
        mau_busy = 1'b1; res_ready = 1'b0;
        issue(1'b1, 8'h10, 16'h4B80, 16'h0000);
        tests++; if (mau_start !== 1'b1 || mau_mode !== 1'b1 || mau_drive !== 1'b1) begin fails++; $display("FAIL basic_start_ctl got=%0b%0b%0b exp=111", mau_start, mau_mode, mau_drive); end
        tests++; if (mau_dbs !== 16'h4B80 || mau_dbi !== 16'h0000) begin fails++; $display("FAIL basic_start_bus got=%h %h exp=4b80 0000", mau_dbs, mau_dbi); end
        tests++; if (ram_addr !== 8'h10 || mau_mat !== 16'h0) begin fails++; $display("FAIL basic_start_addr got=%h mat=%h exp=10 0000", ram_addr, mau_mat); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests++; if (mau_mat !== exp_w[k]) begin fails++; $display("FAIL basic_feed_mat%0d got=%h exp=%h", k, mau_mat, exp_w[k]); end
            tests++; if (ram_addr !== 8'(8'h11 + k) || mau_start !== 1'b0 || mau_drive !== 1'b1) begin fails++; $display("FAIL basic_feed_ctl%0d got addr=%h start=%0b drive=%0b exp addr=%h 0 1", k, ram_addr, mau_start, mau_drive, 8'(8'h11 + k)); end
        end
        for (int n = 6; n <= 15; n++) begin
            @(negedge clk);
            tests++; if (mau_drive !== 1'b1 || mau_dbs !== 16'h4B80 || mau_read !== 1'b0 || mau_mat !== 16'h0) begin fails++; $display("FAIL basic_wait%0d got drive=%0b dbs=%h read=%0b mat=%h exp 1 4b80 0 0000", n, mau_drive, mau_dbs, mau_read, mau_mat); end
            if (n == 15) mau_busy = 1'b0;
        end
        @(negedge clk);
        tests++; if (mau_drive !== 1'b0 || mau_read !== 1'b1 || mau_dbs !== 16'h0) begin fails++; $display("FAIL basic_turn got drive=%0b read=%0b dbs=%h exp 0 1 0000", mau_drive, mau_read, mau_dbs); end
        mau_res_s = 16'h1111; mau_res_i = 16'h2222;
        @(negedge clk);
        tests++; if (mau_read !== 1'b1 || res_valid !== 1'b0) begin fails++; $display("FAIL basic_read got read=%0b valid=%0b exp 1 0", mau_read, res_valid); end
        mau_res_s = 16'hC0DE; mau_res_i = 16'h0F0F;
        @(negedge clk);
        mau_res_s = 16'h9999; mau_res_i = 16'h9999;
        for (int n = 0; n < 3; n++) begin
            tests++; if (res_valid !== 1'b1 || res_s !== 16'hC0DE || res_i !== 16'h0F0F) begin fails++; $display("FAIL basic_hold%0d got valid=%0b %h %h exp 1 c0de 0f0f", n, res_valid, res_s, res_i); end
            if (n == 2) res_ready = 1'b1;
            @(negedge clk);
        end
        tests++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL basic_release got valid=%0b ready=%0b exp 0 1", res_valid, cmd_ready); end
        res_ready = 1'b0;
    endtask

    task automatic test_latency;
        mau_busy = 1'b0; res_ready = 1'b1;
        mau_res_s = 16'h7777; mau_res_i = 16'h8888;
        issue(1'b0, 8'h20, 16'h1234, 16'h5678);
        for (int n = 1; n <= 10; n++) begin
            if (n > 1) @(negedge clk);
            tests++; if (res_valid !== (n == 9)) begin fails++; $display("FAIL lat_valid_n%0d got=%0b exp=%0b", n, res_valid, (n == 9)); end
            if (n == 9) begin
                tests++; if (res_s !== 16'h7777 || res_i !== 16'h8888) begin fails++; $display("FAIL lat_res got=%h %h exp 7777 8888", res_s, res_i); end
            end
        end
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL lat_idle got=%0b exp=1", cmd_ready); end
    endtask

    task automatic test_wrap;
        logic [7:0] ea [4];
        ea = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        mau_busy = 1'b0; res_ready = 1'b1;
        issue(1'b0, 8'hFE, 16'hAAAA, 16'h5555);
        for (int n = 1; n <= 5; n++) begin
            if (n > 1) @(negedge clk);
            if (n <= 4) begin
                tests++; if (ram_addr !== ea[n-1]) begin fails++; $display("FAIL wrap_addr%0d got=%h exp=%h", n, ram_addr, ea[n-1]); end
            end
            if (n >= 2) begin
                tests++; if (mau_mat !== ram[ea[n-2]]) begin fails++; $display("FAIL wrap_mat%0d got=%h exp=%h", n, mau_mat, ram[ea[n-2]]); end
            end
        end
        wait_idle("wrap");
    endtask

    task automatic test_timeout;
        mau_busy = 1'b1; res_ready = 1'b1;
        issue(1'b0, 8'h30, 16'h0001, 16'h0002);
        for (int n = 2; n <= 25; n++) begin
            @(negedge clk);
            tests++; if (res_valid !== 1'b0 || timeout_err !== 1'b0) begin fails++; $display("FAIL to_wait%0d got valid=%0b err=%0b exp 0 0", n, res_valid, timeout_err); end
        end
        tests++; if (mau_drive !== 1'b1) begin fails++; $display("FAIL to_last_wait got drive=%0b exp=1", mau_drive); end
        @(negedge clk);
        tests++; if (timeout_err !== 1'b1 || cmd_ready !== 1'b1 || mau_drive !== 1'b0 || res_valid !== 1'b0) begin fails++; $display("FAIL to_abort got err=%0b ready=%0b drive=%0b valid=%0b exp 1 1 0 0", timeout_err, cmd_ready, mau_drive, res_valid); end
        mau_busy = 1'b0;
        @(negedge clk);
        tests++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL to_sticky got=%0b exp=1", timeout_err); end
        issue(1'b0, 8'h30, 16'h0001, 16'h0002);
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL to_clear got=%0b exp=0", timeout_err); end
        wait_idle("to");
    endtask

    task automatic test_reset_mid;
        mau_busy = 1'b0; res_ready = 1'b1;
        mau_res_s = 16'h4321; mau_res_i = 16'h8765;
        issue(1'b1, 8'h10, 16'h4B80, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        tests++; if (mau_drive !== 1'b0 || mau_start !== 1'b0 || mau_mat !== 16'h0 || ram_addr !== 8'h00) begin fails++; $display("FAIL rmid_outs got drive=%0b start=%0b mat=%h addr=%h exp 0", mau_drive, mau_start, mau_mat, ram_addr); end
        tests++; if (cmd_ready !== 1'b0 || mau_dbs !== 16'h0 || res_s !== 16'h0 || res_valid !== 1'b0) begin fails++; $display("FAIL rmid_outs2 got ready=%0b dbs=%h res_s=%h valid=%0b exp 0", cmd_ready, mau_dbs, res_s, res_valid); end
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            tests++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL rmid_quiet%0d got valid=%0b ready=%0b exp 0 1", n, res_valid, cmd_ready); end
        end
        issue(1'b1, 8'h10, 16'h4B80, 16'h0000);
        for (int n = 2; n <= 9; n++) @(negedge clk);
        tests++; if (res_valid !== 1'b1 || res_s !== 16'h4321 || res_i !== 16'h8765) begin fails++; $display("FAIL rmid_fresh got valid=%0b %h %h exp 1 4321 8765", res_valid, res_s, res_i); end
        wait_idle("rmid");
    endtask

    task automatic test_back_to_back;
        mau_busy = 1'b0; res_ready = 1'b0;
        mau_res_s = 16'hABCD; mau_res_i = 16'hDCBA;
        cmd_mode = 1'b0; cmd_base = 8'h40; cmd_vec_s = 16'h0F00; cmd_vec_i = 16'h00F0;
        cmd_valid = 1'b1;
        @(negedge clk);
        for (int n = 1; n <= 11; n++) begin
            if (n > 1) @(negedge clk);
            tests++; if (cmd_ready !== 1'b0 || mau_start !== (n == 1)) begin fails++; $display("FAIL b2b_busy%0d got ready=%0b start=%0b exp 0 %0b", n, cmd_ready, mau_start, (n == 1)); end
            if (n >= 9) begin
                tests++; if (res_valid !== 1'b1 || res_s !== 16'hABCD || res_i !== 16'hDCBA) begin fails++; $display("FAIL b2b_hold%0d got valid=%0b %h %h exp 1 abcd dcba", n, res_valid, res_s, res_i); end
                mau_res_s = 16'h0000; mau_res_i = 16'h0000;
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        tests++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin fails++; $display("FAIL b2b_idle got ready=%0b valid=%0b exp 1 0", cmd_ready, res_valid); end
        @(negedge clk);
        cmd_valid = 1'b0;
        tests++; if (mau_start !== 1'b1 || mau_dbs !== 16'h0F00) begin fails++; $display("FAIL b2b_second got start=%0b dbs=%h exp 1 0f00", mau_start, mau_dbs); end
        wait_idle("b2b");
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_base = 8'h00;
        cmd_vec_s = 16'h0; cmd_vec_i = 16'h0;
        mau_busy = 1'b0; mau_res_s = 16'h0; mau_res_i = 16'h0; res_ready = 1'b0;
        for (int i = 0; i < 256; i++) ram[i] = 16'(i * 16'h0101) ^ 16'h5A00;
        ram[8'h10] = 16'h3AEE; ram[8'h11] = 16'hB800;
        ram[8'h12] = 16'hBAEE; ram[8'h13] = 16'h3AEE;
        ram[8'hFE] = 16'hCAFE; ram[8'hFF] = 16'hBEEF;
        ram[8'h00] = 16'hD00D; ram[8'h01] = 16'hF00D;
        test_reset;
        test_basic;
        test_latency;
        test_wrap;
        test_timeout;
        test_reset_mid;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
